// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside EX: radix-2 shift-add multiply
// and restoring divide, one iteration per cycle, single HI/LO write on completion.
module muldiv_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  input  logic             annul,
  output logic             stall_req,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [WIDTH-1:0]  opb;      // multiplicand or divisor (magnitude)
  logic [WIDTH-1:0]  acc_hi;   // product high / partial remainder
  logic [WIDTH-1:0]  acc_lo;   // multiplier bits / quotient bits
  logic              sign1;
  logic              sign2;
  logic              is_div;
  logic              is_signed;

  // Issue-time decode and operand magnitudes
  logic              op_signed;
  logic [WIDTH-1:0]  abs1;
  logic [WIDTH-1:0]  abs2;

  always_comb begin
    op_signed = ~op[0];
    abs1      = (op_signed && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    abs2      = (op_signed && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
  end

  // One iteration of the selected algorithm
  logic [WIDTH:0]    add_sum;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    rem_sub;
  logic [WIDTH-1:0]  nxt_hi;
  logic [WIDTH-1:0]  nxt_lo;

  always_comb begin
    add_sum = {1'b0, acc_hi};
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opb};
    nxt_hi  = acc_hi;
    nxt_lo  = acc_lo;
    if (is_div) begin
      if (rem_sh >= {1'b0, opb}) begin
        nxt_hi = rem_sub[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_lo[0]) add_sum = {1'b0, acc_hi} + {1'b0, opb};
      nxt_hi = add_sum[WIDTH:1];
      nxt_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign restoration applied to the result of the final iteration
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  always_comb begin
    prod   = {nxt_hi, nxt_lo};
    fin_hi = nxt_hi;
    fin_lo = nxt_lo;
    if (is_signed) begin
      if (is_div) begin
        if (sign1 ^ sign2) fin_lo = -nxt_lo;
        if (sign1)         fin_hi = -nxt_hi;
      end else if (sign1 ^ sign2) begin
        prod   = -{nxt_hi, nxt_lo};
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      opb       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      done      <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      done <= 1'b0;
      hi_o <= '0;
      lo_o <= '0;
      case (state)
        S_IDLE: begin
          if (start && !annul) begin
            cnt       <= '0;
            is_div    <= op[1];
            is_signed <= op_signed;
            sign1     <= op_signed & opdata1[WIDTH-1];
            sign2     <= op_signed & opdata2[WIDTH-1];
            acc_hi    <= '0;
            if (op[1]) begin
              opb    <= abs2;
              acc_lo <= abs1;
            end else begin
              opb    <= abs1;
              acc_lo <= abs2;
            end
            if (op[1] && (opdata2 == '0)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (annul) begin
            state <= S_IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == CNTW'(WIDTH - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
              hi_o  <= fin_hi;
              lo_o  <= fin_lo;
            end
          end
        end
        default: begin
          // Start stays high here for the same instruction; it is not a new op.
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_req = ((state == S_IDLE) && start && !annul) ||
                     ((state == S_CALC) && !annul);
  assign hilo_we   = done;
  assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: table of mul/div vectors with hand-computed
// HI/LO and latency, plus annul, reset-abort and back-to-back sequences.
module tb_muldiv_seq_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] opdata1 = '0;
  logic [WIDTH-1:0] opdata2 = '0;
  logic             annul = 1'b0;
  logic             stall_req;
  logic             done;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic [1:0]       state_dbg;

  muldiv_seq_ctrl #(.WIDTH(WIDTH), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .stall_req(stall_req), .done(done), .hilo_we(hilo_we),
    .hi_o(hi_o), .lo_o(lo_o), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issues one op in an IDLE cycle, holds start until done, reports latency.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   lat;
    logic stall_ok;
    logic [31:0] rhi, rlo;
    logic we;
    lat = 0; stall_ok = 1'b1; rhi = '0; rlo = '0; we = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; opdata1 = a; opdata2 = b;
    #1;
    check({tag, "_issue_stall"}, 64'(stall_req), 64'd1);
    check({tag, "_idle_outs"}, {hilo_we, done, hi_o, lo_o}, 64'd0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k; rhi = hi_o; rlo = lo_o; we = hilo_we;
        if (stall_req) stall_ok = 1'b0;
        break;
      end
      if (!stall_req) stall_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_stall"}, 64'(stall_ok), 64'd1);
    check({tag, "_hi"}, 64'(rhi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(rlo), 64'(exp_lo));
    check({tag, "_we"}, 64'(we), 64'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];
  int   ops_done = 0;

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 33, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{2'b00, 32'h00000000, 32'h12345678, 33, 32'h00000000, 32'h00000000};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'b11, 32'h00000007, 32'h00000002, 33, 32'h00000001, 32'h00000003};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000};
    vecs[6]  = '{2'b11, 32'h00000005, 32'h00000000, 1,  32'h00000000, 32'h00000000};
    vecs[7]  = '{2'b00, 32'hFFFFFFFD, 32'hFFFFFFF9, 33, 32'h00000000, 32'h00000015};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 33, 32'h00000000, 32'hFFFFFFFF};
    vecs[10] = '{2'b01, 32'h12345678, 32'h00000010, 33, 32'h00000001, 32'h23456780};
    vecs[11] = '{2'b00, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000};

    // Reset state while rst is held
    repeat (2) @(negedge clk);
    check("rst_outs", {hilo_we, done, hi_o, lo_o}, 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;

    // Table vectors, issued back to back
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].lat, vecs[i].hi, vecs[i].lo);
      ops_done++;
    end

    // Annul mid-divide: drop at T+10, new MULTU issued at T+12
    @(negedge clk);
    start = 1'b1; op = 2'b11; opdata1 = 32'd100; opdata2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) annul = 1'b1;
    end
    #1;
    check("annul_stall_t10", 64'(stall_req), 64'd0);
    @(negedge clk);
    check("annul_state_t11", 64'(state_dbg), 64'd0);
    check("annul_outs_t11", {hilo_we, done, stall_req, hi_o, lo_o}, 64'd0);
    start = 1'b0; annul = 1'b0;
    run_op("post_annul", 2'b01, 32'd2, 32'd3, 33, 32'd0, 32'd6);
    ops_done++;

    // Reset asserted mid-CALC aborts the op
    @(negedge clk);
    start = 1'b1; op = 2'b10; opdata1 = 32'hFFFFFF9C; opdata2 = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) begin rst = 1'b1; start = 1'b0; end
    end
    @(negedge clk);
    check("rst_mid_outs", {hilo_we, done, stall_req, hi_o, lo_o}, 64'd0);
    check("rst_mid_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_op("post_rst", 2'b11, 32'd7, 32'd2, 33, 32'd1, 32'd3);
    ops_done++;

    @(negedge clk);
    check("done_pulses", 64'(done_cnt), 64'(ops_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
